// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter with configurable frame format and a write FIFO
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          din,
    input  logic                          wr_en,
    input  logic                          txclken,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count_nxt;
    logic                 push;
    logic                 pop;

    logic [2:0]           state;
    logic [DATA_BITS-1:0] shreg;
    logic [BW-1:0]        bit_cnt;
    logic                 stop_cnt;
    logic                 stop_last;
    logic                 par_bit;

    assign tx_busy   = (state != S_IDLE);
    assign push      = wr_en && !full;
    // The final stop pulse is the second one only when two stop bits are configured.
    assign stop_last = (STOP_BITS == 2) ? stop_cnt : 1'b1;
    assign pop       = !empty && ((state == S_IDLE) ||
                                  (state == S_STOP && txclken && stop_last));
    assign par_bit   = (PARITY == 2) ? ~(^shreg) : (^shreg);

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count    <= count_nxt;
            full     <= (count_nxt == CW'(FIFO_DEPTH));
            empty    <= (count_nxt == '0);
            overflow <= wr_en && full;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            tx       <= 1'b1;
            shreg    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shreg    <= mem[rd_ptr];
                        bit_cnt  <= '0;
                        stop_cnt <= 1'b0;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    if (txclken) begin
                        tx    <= 1'b0;
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (txclken) begin
                        tx <= shreg[bit_cnt];
                        if (bit_cnt == BW'(DATA_BITS - 1)) begin
                            state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (txclken) begin
                        tx    <= par_bit;
                        state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (txclken) begin
                        tx <= 1'b1;
                        if (stop_last) begin
                            // Reload straight from the FIFO so queued frames leave with no idle gap.
                            if (pop) begin
                                shreg    <= mem[rd_ptr];
                                bit_cnt  <= '0;
                                stop_cnt <= 1'b0;
                                state    <= S_START;
                            end else begin
                                state <= S_IDLE;
                            end
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo (default and 7O2 builds)
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       txclken = 1'b0;
    logic [7:0] din = '0;
    logic       wr_en = 1'b0;
    logic       tx, tx_busy, full, empty, overflow;
    logic [2:0] count;
    logic [6:0] din7 = '0;
    logic       wr_en7 = 1'b0;
    logic       tx7, busy7, full7, empty7, overflow7;
    logic [2:0] count7;

    int checks = 0;
    int failures = 0;
    int bits_seen = 0;
    int bits7 = 0;
    bit exp_q[$];
    bit exp7_q[$];

    bit tick_en = 1'b0;
    int tick_period = 16;
    int tick_cnt = 0;

    uart_tx_fifo u_dut (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .txclken(txclken),
        .tx(tx), .tx_busy(tx_busy), .full(full), .empty(empty),
        .count(count), .overflow(overflow)
    );

    uart_tx_fifo #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut7 (
        .clk(clk), .rst(rst), .din(din7), .wr_en(wr_en7), .txclken(txclken),
        .tx(tx7), .tx_busy(busy7), .full(full7), .empty(empty7),
        .count(count7), .overflow(overflow7)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!tick_en) begin
            txclken = 1'b0;
            tick_cnt = 0;
        end else begin
            txclken = (tick_cnt == tick_period - 1);
            tick_cnt = (tick_cnt == tick_period - 1) ? 0 : tick_cnt + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // A line bit is produced on every enabled tick that finds the FSM busy.
    always @(posedge clk) begin
        if (!rst && txclken && tx_busy) begin
            #1;
            bits_seen++;
            if (exp_q.size() == 0) chk("line_bit_unexpected", int'(tx), -1);
            else chk("line_bit", int'(tx), int'(exp_q.pop_front()));
        end
    end

    always @(posedge clk) begin
        if (!rst && txclken && busy7) begin
            #1;
            bits7++;
            if (exp7_q.size() == 0) chk("line_bit7_unexpected", int'(tx7), -1);
            else chk("line_bit7", int'(tx7), int'(exp7_q.pop_front()));
        end
    end

    task automatic push_frame8(input logic [7:0] d);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        exp_q.push_back(1'b1);
    endtask

    task automatic wr8(input logic [7:0] d);
        @(negedge clk);
        din = d;
        wr_en = 1'b1;
    endtask

    task automatic wr_end();
        @(negedge clk);
        wr_en = 1'b0;
        wr_en7 = 1'b0;
    endtask

    task automatic wait_idle(input bit which, input int budget);
        int n;
        n = 0;
        while ((which ? busy7 : tx_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) chk("idle_timeout", n, -1);
    endtask

    initial begin
        bit a5_bits[10] = '{0,1,0,1,0,0,1,0,1,1};
        bit b41_bits[11] = '{0,1,0,0,0,0,0,1,1,1,1};
        int bad;
        int n;

        repeat (3) @(negedge clk);
        chk("rst_tx", int'(tx), 1);
        chk("rst_busy", int'(tx_busy), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_overflow", int'(overflow), 0);
        rst = 1'b0;
        @(negedge clk);

        // Single A5 frame at one tick per 16 clocks.
        tick_period = 16;
        tick_en = 1'b1;
        bits_seen = 0;
        foreach (a5_bits[i]) exp_q.push_back(a5_bits[i]);
        wr8(8'hA5);
        wr_end();
        @(negedge clk);
        chk("a5_empty_after_pop", int'(empty), 1);
        chk("a5_busy_after_pop", int'(tx_busy), 1);
        wait_idle(1'b0, 400);
        chk("a5_bits_while_busy", bits_seen, 10);
        chk("a5_queue_drained", exp_q.size(), 0);
        chk("a5_tx_idle", int'(tx), 1);

        // Six writes with no ticks: one popped, four queued, one dropped.
        tick_en = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 1; i <= 5; i++) push_frame8(8'(i));
        wr8(8'h01); wr8(8'h02); wr8(8'h03); wr8(8'h04); wr8(8'h05);
        wr8(8'h06);
        chk("burst_full_before_drop", int'(full), 1);
        chk("burst_no_overflow_yet", int'(overflow), 0);
        wr_end();
        chk("burst_overflow_pulse", int'(overflow), 1);
        chk("burst_count", int'(count), 4);
        @(negedge clk);
        chk("burst_overflow_one_cycle", int'(overflow), 0);
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b1) bad++;
        end
        chk("hold_no_toggle", bad, 0);
        bits_seen = 0;
        tick_period = 1;
        tick_en = 1'b1;
        n = 0;
        while (bits_seen < 1 && n < 20) begin @(negedge clk); n++; end
        chk("hold_first_tick_start", int'(tx), 0);
        wait_idle(1'b0, 200);
        chk("burst_bits", bits_seen, 50);
        chk("burst_queue_drained", exp_q.size(), 0);
        chk("burst_empty", int'(empty), 1);

        // Three queued words with continuous ticks must run gapless.
        bits_seen = 0;
        push_frame8(8'h00); push_frame8(8'hFF); push_frame8(8'h3C);
        wr8(8'h00); wr8(8'hFF); wr8(8'h3C);
        wr_end();
        wait_idle(1'b0, 100);
        chk("gapless_bits_before_idle", bits_seen, 30);
        chk("gapless_queue_drained", exp_q.size(), 0);

        // 7 data bits, odd parity, two stop bits.
        tick_period = 4;
        bits7 = 0;
        foreach (b41_bits[i]) exp7_q.push_back(b41_bits[i]);
        @(negedge clk);
        din7 = 7'h41;
        wr_en7 = 1'b1;
        wr_end();
        @(negedge clk);
        wait_idle(1'b1, 200);
        chk("p7_frame_bits", bits7, 11);
        chk("p7_queue_drained", exp7_q.size(), 0);

        // Asynchronous reset in the middle of a data bit with two words queued.
        tick_period = 8;
        bits_seen = 0;
        push_frame8(8'h11);
        wr8(8'h11); wr8(8'h22); wr8(8'h33);
        wr_end();
        n = 0;
        while (bits_seen < 3 && n < 200) begin @(negedge clk); n++; end
        chk("rst_mid_reached_data", int'(bits_seen >= 3), 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_tx", int'(tx), 1);
        chk("rst_mid_busy", int'(tx_busy), 0);
        chk("rst_mid_empty", int'(empty), 1);
        chk("rst_mid_count", int'(count), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_full", int'(full), 0);
        chk("rst_mid_overflow", int'(overflow), 0);
        bits_seen = 0;
        push_frame8(8'h5A);
        wr8(8'h5A);
        wr_end();
        @(negedge clk);
        wait_idle(1'b0, 300);
        chk("post_rst_bits", bits_seen, 10);
        chk("post_rst_queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with a built-in write FIFO. It succeeds the fixed 8N1 `transmitter` in the UART path. Data width, parity mode and stop-bit count are configurable. Writes are queued, so the bus can burst words while a frame is on the line, and queued frames go out back-to-back with no idle gap.

## Interface
- DATA_BITS, 8, data bits per frame; legal range 5..9
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd
- STOP_BITS, 1, number of stop bits; 1 or 2
- FIFO_DEPTH, 4, FIFO entries; power of two, at least 2
- clk  in  1  system clock; the single clock for the whole block
- rst  in  1  reset, asynchronous, active-high
- din  in  DATA_BITS  write data, sampled when wr_en=1
- wr_en  in  1  write strobe; one word per clk cycle
- txclken  in  1  bit-rate enable; single-cycle pulse, one line bit per pulse
- tx  out  1  serial line; idles high
- tx_busy  out  1  high whenever the FSM is not in IDLE
- full  out  1  FIFO holds FIFO_DEPTH words
- empty  out  1  FIFO holds 0 words
- count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- overflow  out  1  one-cycle pulse when a write is dropped

## Operation
- FIFO is a circular buffer with wrapping read and write pointers. count, full and empty are registered.
- A write is accepted when wr_en=1 and full=0.
  - When wr_en=1 and full=1, the word is dropped and overflow=1 for that one cycle. This holds even if a pop occurs in the same cycle.
  - A push and pop in the same cycle both take effect and count is unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx=1. If empty=0, pop the head into the shift register, clear the bit counter and go to START. txclken is ignored in IDLE.
- START: on txclken, tx<=0 and go to DATA.
- DATA: on each txclken, tx<=shift register bit[bitcnt], sent LSB first.
  - After bit DATA_BITS-1, go to PARITY if PARITY!=0, otherwise go to STOP.
- PARITY: on txclken, tx<=parity bit and go to STOP.
  - Even parity: parity bit = XOR of the data bits.
  - Odd parity: the inverse of the even-parity bit.
- STOP: on each txclken, tx<=1. On the STOP_BITS-th stop pulse:
  - if empty=0, pop the next word in that same cycle and go to START (gapless);
  - otherwise go to IDLE.
- Frame length is 1+DATA_BITS+(PARITY!=0)+STOP_BITS txclken periods. Each bit holds from its txclken pulse until the next one.
- If txclken stays low, the FSM holds its state and tx holds its value. tx_busy stays 1 and does not toggle.
- Reset, asynchronous and applicable mid-frame:
  - tx=1, tx_busy=0, state=IDLE;
  - FIFO flushed: count=0, empty=1, full=0;
  - overflow=0; shift register and counters cleared.
  - The partial frame is abandoned.

## Timing
- tx is driven from a register. Every output is registered except tx_busy, which is decoded from the state register.
- Write into an empty FIFO while in IDLE:
  - word stored at edge k;
  - pop at edge k+1, with tx_busy=1 after edge k+1;
  - tx falls at the first edge with txclken=1 after edge k+1.
- After a pop, count drops on the same edge.
- tx_busy falls on the edge that takes the FSM to IDLE, i.e. at the last stop-bit pulse. The line then stays at 1.
- Back-to-back frames: the last stop bit lasts exactly one txclken period, and the next start bit begins on the following pulse.

## Test plan
- Defaults, single write din=8'hA5, txclken every 16 clk:
  - tx bit sequence per tick is 0,1,0,1,0,0,1,0,1,1;
  - tx_busy high for exactly 10 tick periods;
  - empty=1 from the cycle after the write.
- Defaults, txclken=0, six consecutive writes 8'h01..8'h06:
  - 8'h01 is popped;
  - 8'h02..8'h05 queued, count=4, full=1;
  - 8'h06 dropped with a one-cycle overflow pulse.
- Three words queued (8'h00, 8'hFF, 8'h3C), continuous txclken:
  - 30 tick periods with no idle gap;
  - each stop bit exactly one period;
  - tx_busy=1 throughout.
- DATA_BITS=7, PARITY=2, STOP_BITS=2, din=7'h41:
  - line bits are 0,1,0,0,0,0,0,1,1,1,1, where the odd parity bit is 1;
  - frame is 11 ticks.
- Word written, txclken held 0 for 1000 cycles:
  - tx=1 and tx_busy=1 for the whole window, with no toggling;
  - the first txclken afterwards drives tx=0.
- rst pulsed during DATA with 2 words queued:
  - tx=1, tx_busy=0, empty=1, count=0 immediately, without waiting for a clk edge;
  - after release, a write of 8'h5A produces a correct frame.
